// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns a level-held load/store request into one or two
// word-wide RAM beats with byte enables, and returns right-aligned load data with a ready pulse.
module dmem_ctrl #(
  parameter int ADDR_W   = 14,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data,
  input  logic [1:0]        byte_size,
  output logic [31:0]       mem_data_in,
  output logic              mem_read_ready,
  output logic              mem_write_ready,
  output logic              mem_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [1:0] {IDLE, B0, B1, RESP} state_t;

  state_t            state_reg;
  logic              rd_reg;
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic [3:0]        be1_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic [31:0]       wdata1_reg;
  logic [63:0]       buf_reg;

  logic [7:0]        lane_base;
  logic [7:0]        lane_mask;
  logic [31:0]       data_mask;
  logic [63:0]       wide_data;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              straddle;
  logic              unused_addr_bits;

  always_comb begin
    lane_base = 8'h0F;
    data_mask = 32'hFFFF_FFFF;
    case (byte_size)
      2'd1: begin
        lane_base = 8'h01;
        data_mask = 32'h0000_00FF;
      end
      2'd2: begin
        lane_base = 8'h03;
        data_mask = 32'h0000_FFFF;
      end
      default: begin
        lane_base = 8'h0F;
        data_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Lanes and data for both beats are computed as one 8-lane / 64-bit window.
  assign lane_mask = lane_base << mem_addr[1:0];
  assign wide_data = {32'b0, mem_data & data_mask} << {mem_addr[1:0], 3'b000};
  assign addr0     = mem_addr[ADDR_W+1:2];
  assign addr1     = addr0 + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign straddle  = |lane_mask[7:4];
  assign unused_addr_bits = &{1'b0, mem_addr[31:ADDR_W+2]};

  function automatic logic [31:0] load_align(input logic [63:0] b, input logic [1:0] off,
                                             input logic [1:0] sz);
    logic [63:0] s;
    s = b >> {off, 3'b000};
    case (sz)
      2'd1:    load_align = {24'b0, s[7:0]};
      2'd2:    load_align = {16'b0, s[15:0]};
      default: load_align = s[31:0];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rd_reg          <= 1'b0;
      off_reg         <= 2'b0;
      size_reg        <= 2'b0;
      be1_reg         <= 4'b0;
      addr1_reg       <= '0;
      wdata1_reg      <= 32'b0;
      buf_reg         <= 64'b0;
      mem_data_in     <= 32'b0;
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_err         <= 1'b0;
      ram_req         <= 1'b0;
      ram_we          <= 1'b0;
      ram_be          <= 4'b0;
      ram_addr        <= '0;
      ram_wdata       <= 32'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_read_en || mem_write_en) begin
            rd_reg     <= mem_read_en;
            off_reg    <= mem_addr[1:0];
            size_reg   <= byte_size;
            be1_reg    <= lane_mask[7:4];
            addr1_reg  <= addr1;
            wdata1_reg <= mem_read_en ? 32'b0 : wide_data[63:32];
            if (straddle && !SPLIT_EN) begin
              state_reg       <= RESP;
              mem_err         <= 1'b1;
              mem_read_ready  <= mem_read_en;
              mem_write_ready <= !mem_read_en;
              mem_data_in     <= 32'b0;
            end else begin
              state_reg <= B0;
              ram_req   <= 1'b1;
              ram_we    <= !mem_read_en;
              ram_be    <= lane_mask[3:0];
              ram_addr  <= addr0;
              ram_wdata <= mem_read_en ? 32'b0 : wide_data[31:0];
            end
          end
        end
        B0: begin
          if (ram_ack) begin
            buf_reg[31:0] <= ram_rdata;
            if (be1_reg != 4'b0) begin
              state_reg <= B1;
              ram_be    <= be1_reg;
              ram_addr  <= addr1_reg;
              ram_wdata <= wdata1_reg;
            end else begin
              state_reg       <= RESP;
              ram_req         <= 1'b0;
              ram_we          <= 1'b0;
              ram_be          <= 4'b0;
              ram_addr        <= '0;
              ram_wdata       <= 32'b0;
              mem_read_ready  <= rd_reg;
              mem_write_ready <= !rd_reg;
              mem_data_in     <= rd_reg ? load_align({buf_reg[63:32], ram_rdata}, off_reg, size_reg)
                                        : 32'b0;
            end
          end
        end
        B1: begin
          if (ram_ack) begin
            buf_reg[63:32]  <= ram_rdata;
            state_reg       <= RESP;
            ram_req         <= 1'b0;
            ram_we          <= 1'b0;
            ram_be          <= 4'b0;
            ram_addr        <= '0;
            ram_wdata       <= 32'b0;
            mem_read_ready  <= rd_reg;
            mem_write_ready <= !rd_reg;
            mem_data_in     <= rd_reg ? load_align({ram_rdata, buf_reg[31:0]}, off_reg, size_reg)
                                      : 32'b0;
          end
        end
        default: begin
          // RESP: the upstream drops its enable on the edge that ends this cycle.
          state_reg       <= IDLE;
          mem_read_ready  <= 1'b0;
          mem_write_ready <= 1'b0;
          mem_err         <= 1'b0;
          mem_data_in     <= 32'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-level RAM model drives randomized and directed loads/stores and
// checks every beat, latency and returned value; a second instance covers SPLIT_EN=0.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_data;
  logic [1:0]  byte_size;
  logic [31:0] mem_data_in;
  logic        mem_read_ready, mem_write_ready, mem_err;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_ack;

  logic        ns_read_en, ns_write_en;
  logic [31:0] ns_addr, ns_data;
  logic [1:0]  ns_size;
  logic [31:0] ns_data_in;
  logic        ns_read_ready, ns_write_ready, ns_err;
  logic        ns_ram_req, ns_ram_we;
  logic [3:0]  ns_ram_be;
  logic [13:0] ns_ram_addr;
  logic [31:0] ns_ram_wdata, ns_ram_rdata;
  logic        ns_ram_ack;

  logic [31:0] ram [0:16383];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(14), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .byte_size(byte_size), .mem_data_in(mem_data_in),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready), .mem_err(mem_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  dmem_ctrl #(.ADDR_W(14), .SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst(rst), .mem_read_en(ns_read_en), .mem_write_en(ns_write_en),
    .mem_addr(ns_addr), .mem_data(ns_data), .byte_size(ns_size), .mem_data_in(ns_data_in),
    .mem_read_ready(ns_read_ready), .mem_write_ready(ns_write_ready), .mem_err(ns_err),
    .ram_req(ns_ram_req), .ram_we(ns_ram_we), .ram_be(ns_ram_be), .ram_addr(ns_ram_addr),
    .ram_wdata(ns_ram_wdata), .ram_rdata(ns_ram_rdata), .ram_ack(ns_ram_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access against the byte-level RAM model; expected beats come from walking the bytes.
  task automatic access(input bit rd, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [31:0] data, input bit hold_wr, input int wmin, input int wmax,
                        output logic [31:0] got);
    int n, nb, beat, waitcnt, waits, cycles;
    bit acked, done;
    logic [13:0] ea [2];
    logic [3:0]  eb [2];
    logic [31:0] ew [2];
    logic [31:0] exp_rd, a;
    logic [13:0] wa;
    logic [1:0]  ln;
    n = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    nb = 0;
    exp_rd = 32'b0;
    got = 32'b0;
    for (int k = 0; k < n; k++) begin
      a  = addr + k;
      wa = a[15:2];
      ln = a[1:0];
      if (nb == 0 || ea[nb-1] != wa) begin
        ea[nb] = wa; eb[nb] = 4'b0; ew[nb] = 32'b0; nb++;
      end
      eb[nb-1][ln] = 1'b1;
      ew[nb-1][8*ln +: 8] = data[8*k +: 8];
      exp_rd[8*k +: 8] = ram[wa][8*ln +: 8];
    end
    mem_addr = addr; byte_size = sz; mem_data = data;
    mem_read_en = rd; mem_write_en = !rd || hold_wr;
    beat = 0; waits = 0; cycles = 0; acked = 0; done = 0;
    waitcnt = $urandom_range(wmax, wmin);
    while (!done && cycles < 60) begin
      @(posedge clk); cycles++; @(negedge clk);
      if (acked) begin
        beat++; acked = 0; ram_ack = 1'b0;
        waitcnt = $urandom_range(wmax, wmin);
      end
      if (mem_read_ready || mem_write_ready) begin
        done = 1;
        got = mem_data_in;
        check("beats", beat, nb);
        check("latency", cycles, 2 + nb - 1 + waits);
        check("read_ready", mem_read_ready, rd);
        check("write_ready", mem_write_ready, !rd);
        check("err", mem_err, 1'b0);
        check("req_in_resp", ram_req, 1'b0);
        if (rd) check("load_data", mem_data_in, exp_rd);
        mem_read_en = 1'b0;
        if (!hold_wr) mem_write_en = 1'b0;
      end else if (ram_req && beat < nb) begin
        check("beat_addr", ram_addr, ea[beat]);
        check("beat_be", ram_be, eb[beat]);
        check("beat_we", ram_we, !rd);
        if (!rd) check("beat_wdata", ram_wdata, ew[beat]);
        if (waitcnt == 0) begin
          ram_ack = 1'b1; acked = 1;
          ram_rdata = rd ? ram[ea[beat]] : $urandom;
          if (!rd)
            for (int l = 0; l < 4; l++)
              if (eb[beat][l]) ram[ea[beat]][8*l +: 8] = ew[beat][8*l +: 8];
        end else begin
          waitcnt--; waits++;
          ram_rdata = $urandom;
        end
      end else begin
        check("req_vs_beats", ram_req, beat < nb);
      end
    end
    if (!done) check("ready_timeout", mem_read_ready | mem_write_ready, 1'b1);
    ram_ack = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {mem_read_ready, mem_write_ready}, 2'b00);
    check("req_after_resp", ram_req, 1'b0);
    $display("access %s addr=%h size=%0d data=%h beats=%0d cycles=%0d load=%h",
             rd ? "rd" : "wr", addr, sz, data, nb, cycles, got);
  endtask

  // SPLIT_EN=0 instance: a straddling access must answer with err and no RAM beat.
  task automatic ns_err_access(input bit rd, input logic [31:0] addr, input logic [1:0] sz);
    int cycles;
    bit done;
    ns_addr = addr; ns_size = sz; ns_data = $urandom;
    ns_read_en = rd; ns_write_en = !rd;
    cycles = 0; done = 0;
    while (!done && cycles < 10) begin
      @(posedge clk); cycles++; @(negedge clk);
      check("ns_no_req", ns_ram_req, 1'b0);
      if (ns_read_ready || ns_write_ready) done = 1;
    end
    check("ns_latency", cycles, 1);
    check("ns_err", ns_err, 1'b1);
    check("ns_read_ready", ns_read_ready, rd);
    check("ns_write_ready", ns_write_ready, !rd);
    check("ns_data", ns_data_in, 32'b0);
    ns_read_en = 1'b0; ns_write_en = 1'b0;
    @(negedge clk);
    check("ns_err_pulse", {ns_err, ns_read_ready, ns_write_ready}, 3'b000);
    $display("ns access %s addr=%h size=%0d cycles=%0d", rd ? "rd" : "wr", addr, sz, cycles);
  endtask

  initial begin
    logic [31:0] got, addr, data;
    logic [1:0]  sz;
    bit          rd, hold, saw_b1;
    rst = 1'b1;
    mem_read_en = 0; mem_write_en = 0; mem_addr = 0; mem_data = 0; byte_size = 0;
    ram_rdata = 0; ram_ack = 0;
    ns_read_en = 0; ns_write_en = 0; ns_addr = 0; ns_data = 0; ns_size = 0;
    ns_ram_rdata = 0; ns_ram_ack = 0;
    for (int i = 0; i < 16384; i++) ram[i] = $urandom;

    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_data_in, mem_read_ready, mem_write_ready, mem_err, ram_req, ram_we,
                          ram_be, ram_addr}, '0);
    check("rst_wdata", ram_wdata, 32'b0);
    check("rst_ns_outputs", {ns_data_in, ns_read_ready, ns_write_ready, ns_err, ns_ram_req}, '0);
    rst = 1'b0;
    @(negedge clk);

    ram[14'h40] = 32'hDEADBEEF;
    access(1, 32'h0000_0100, 2'd0, 32'h0, 0, 3, 3, got);
    check("lw_0x100", got, 32'hDEADBEEF);
    access(0, 32'h0000_0203, 2'd1, 32'h0000_005A, 0, 0, 0, got);
    check("sb_0x203_mem", ram[14'h80][31:24], 8'h5A);
    ram[1] = 32'hAB00_0000; ram[2] = 32'h0000_00CD;
    access(1, 32'h0000_0007, 2'd2, 32'h0, 0, 0, 1, got);
    check("lh_0x07", got, 32'h0000_CDAB);
    access(0, 32'h0000_000A, 2'd0, 32'h1122_3344, 0, 0, 2, got);
    access(1, 32'h0000_000A, 2'd3, 32'h0, 0, 0, 0, got);
    check("lw_after_sw", got, 32'h1122_3344);
    access(1, 32'h0000_FFFF, 2'd2, 32'h0, 0, 0, 1, got);
    access(0, 32'h0000_FFFE, 2'd0, 32'hCAFE_F00D, 0, 0, 1, got);
    access(1, 32'h0000_FFFE, 2'd0, 32'h0, 0, 0, 0, got);
    check("wrap_rw", got, 32'hCAFE_F00D);
    access(1, 32'h0000_0021, 2'd2, 32'h5555_AAAA, 1, 0, 1, got);
    access(0, 32'h0000_0021, 2'd2, 32'h5555_AAAA, 0, 0, 1, got);
    access(1, 32'h0000_0021, 2'd2, 32'h0, 0, 0, 0, got);
    check("read_wins_then_write", got, 32'h0000_AAAA);

    ns_err_access(1, 32'h0000_0001, 2'd0);
    ns_err_access(0, 32'h0000_0003, 2'd2);

    // Reset while the second beat of a split store is outstanding.
    mem_addr = 32'h0000_000A; byte_size = 2'd0; mem_data = 32'h99887766;
    mem_write_en = 1'b1;
    saw_b1 = 0;
    for (int c = 0; c < 20 && !saw_b1; c++) begin
      @(posedge clk); @(negedge clk);
      if (ram_req && ram_addr == 14'h3) saw_b1 = 1;
      else ram_ack = ram_req && !ram_ack;
    end
    ram_ack = 1'b0;
    check("reached_b1", saw_b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", ram_req, 1'b0);
    check("rst_async_bus", {ram_we, ram_be, ram_addr, ram_wdata}, '0);
    mem_write_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_ready_after_rst", {mem_read_ready, mem_write_ready, ram_req}, 3'b000);
    end
    $display("reset during split store: beat1_seen=%0d", saw_b1);

    for (int i = 0; i < 40; i++) begin
      rd   = $urandom_range(1, 0);
      hold = rd && ($urandom_range(3, 0) == 0);
      sz   = 2'($urandom_range(3, 0));
      data = $urandom;
      addr = ($urandom & 32'hFFFF_0000) |
             (($urandom_range(1, 0) == 1) ? $urandom_range(40, 0) : $urandom_range(32'hFFFF, 32'hFFF0));
      access(rd, addr, sz, data, hold, 0, 2, got);
      if (hold) access(0, addr, sz, data, 0, 0, 2, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
